// File: rtl/dl_pkg.sv
// Shared definitions for the ioctl download controller.
//   dl_state_t      : download/reset sequencing FSM states
//   IDX_*           : ioctl_index values that select a download target
//   MOD_*           : board-variant codes carried by the MOD download
//   is_dl_index()   : true for an ioctl_index this block acts on
package dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_ROM = 3'd1,
    ST_LOAD_CFG = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RUN      = 3'd4
  } dl_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam logic [7:0] MOD_ORIG  = 8'd0;
  localparam logic [7:0] MOD_PLUS  = 8'd1;
  localparam logic [7:0] MOD_CLUB  = 8'd2;
  localparam logic [7:0] MOD_ORCA  = 8'd3;
  localparam logic [7:0] MOD_SHOOT = 8'd4;
  localparam logic [7:0] MOD_CROKY = 8'd5;
  localparam logic [7:0] MOD_GORK  = 8'd6;
  localparam logic [7:0] MOD_MRTNT = 8'd7;
  localparam logic [7:0] MOD_WOODP = 8'd8;
  localparam logic [7:0] MOD_EEEK  = 8'd9;
  localparam logic [7:0] MOD_ALIB  = 8'd10;
  localparam logic [7:0] MOD_PONP  = 8'd11;
  localparam logic [7:0] MOD_VAN   = 8'd12;

  function automatic logic is_dl_index(input logic [7:0] idx);
    return (idx == IDX_ROM) || (idx == IDX_MOD) || (idx == IDX_DIP);
  endfunction

endpackage

// File: rtl/dl_hold_timer.sv
// Loadable down-counter used for the post-download core reset hold.
// Ports:
//   clk  : system clock
//   load : reload the counter with HOLD_CYCLES-1
//   done : counter has reached zero (stays there until the next load)
module dl_hold_timer #(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic load,
  output logic done
);

  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [W-1:0] cnt = '0;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= W'(HOLD_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rom_download_ctrl.sv
// Routes the HPS ioctl download stream into the arcade core: ROM bytes to
// the dn_* write port, the variant byte to mod, DIP bytes to sw. Owns the
// core reset, holding it during downloads, for HOLD_CYCLES afterwards, and
// until a complete in-range ROM image has been loaded.
// Ports:
//   CLK, RESET                    : clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : download stream from hps_io
//   dn_addr, dn_data, dn_wr       : registered ROM write port to the core
//   mod, sw                       : variant byte, eight DIP bytes
//   rom_valid, rom_ovf            : image status flags
//   core_reset                    : registered reset to the core
//
// state       | meaning
// ST_IDLE     | no usable image, core held in reset
// ST_LOAD_ROM | ROM download in progress
// ST_LOAD_CFG | MOD or DIP download in progress
// ST_HOLD     | settle time after a download or RESET
// ST_RUN      | core released
module rom_download_ctrl
  import dl_pkg::*;
#(
  parameter int ROM_BYTES   = 16384,
  parameter int DN_AW       = 16,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic [DN_AW-1:0] dn_addr,
  output logic [7:0]       dn_data,
  output logic             dn_wr,
  output logic [7:0]       mod,
  output logic [63:0]      sw,
  output logic             rom_valid,
  output logic             rom_ovf,
  output logic             core_reset
);

  // Power-up values only: the configuration and flags must survive RESET.
  logic             dl_q         = 1'b0;
  dl_state_t        state        = ST_IDLE;
  dl_state_t        state_next;
  logic             core_reset_q = 1'b1;
  logic [16:0]      byte_cnt     = '0;
  logic             rom_valid_q  = 1'b0;
  logic             rom_ovf_q    = 1'b0;
  logic [7:0]       mod_q        = 8'h00;
  logic [63:0]      sw_q         = '1;
  logic [DN_AW-1:0] dn_addr_q    = '0;
  logic [7:0]       dn_data_q    = 8'h00;
  logic             dn_wr_q      = 1'b0;

  logic rise, fall, wr_ok, rom_wr, in_range, rom_start, rom_leave;
  logic tmr_load, tmr_done;

  assign rise     = ioctl_download & ~dl_q;
  assign fall     = ~ioctl_download & dl_q;
  assign wr_ok    = ioctl_download & ioctl_wr & is_dl_index(ioctl_index);
  assign rom_wr   = wr_ok & (ioctl_index == IDX_ROM);
  assign in_range = (ioctl_addr < 25'(ROM_BYTES));

  // RESET wins over a download edge, so neither image bookkeeping event
  // happens while it is asserted.
  assign rom_start = ~RESET & rise & (ioctl_index == IDX_ROM);
  assign rom_leave = ~RESET & fall & (state == ST_LOAD_ROM);

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    if (RESET) begin
      state_next = ST_HOLD;
      tmr_load   = 1'b1;
    end else if (rise && ioctl_index == IDX_ROM) begin
      state_next = ST_LOAD_ROM;
    end else if (rise && (ioctl_index == IDX_MOD || ioctl_index == IDX_DIP)) begin
      state_next = ST_LOAD_CFG;
    end else begin
      case (state)
        ST_LOAD_ROM, ST_LOAD_CFG: begin
          if (fall) begin
            state_next = ST_HOLD;
            tmr_load   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_done) state_next = rom_valid_q ? ST_RUN : ST_IDLE;
        end
        ST_IDLE: begin
          if (rom_valid_q) state_next = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    dl_q         <= ioctl_download;
    state        <= state_next;
    core_reset_q <= (state_next != ST_RUN);

    // A write landing on the start cycle itself still counts.
    if (rom_start) begin
      byte_cnt    <= (rom_wr && in_range) ? 17'd1 : 17'd0;
      rom_ovf_q   <= rom_wr && !in_range;
      rom_valid_q <= 1'b0;
    end else begin
      if (rom_leave) rom_valid_q <= (byte_cnt == 17'(ROM_BYTES)) & ~rom_ovf_q;
      if (rom_wr) begin
        if (!in_range)              rom_ovf_q <= 1'b1;
        else if (byte_cnt != '1)    byte_cnt  <= byte_cnt + 17'd1;
      end
    end

    if (RESET) begin
      dn_wr_q   <= 1'b0;
      dn_addr_q <= '0;
      dn_data_q <= 8'h00;
    end else begin
      dn_wr_q <= rom_wr & in_range;
      if (rom_wr && in_range) begin
        dn_addr_q <= ioctl_addr[DN_AW-1:0];
        dn_data_q <= ioctl_dout;
      end
    end

    if (wr_ok && ioctl_index == IDX_MOD) mod_q <= ioctl_dout;
    if (wr_ok && ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0)
      sw_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
  end

  dl_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (CLK),
    .load (tmr_load),
    .done (tmr_done)
  );

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign mod        = mod_q;
  assign sw         = sw_q;
  assign rom_valid  = rom_valid_q;
  assign rom_ovf    = rom_ovf_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
module tb_rom_download_ctrl;
  import dl_pkg::*;

  localparam int ROM_BYTES = 16384;
  localparam int HOLD      = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data, mod;
  logic        dn_wr, rom_valid, rom_ovf, core_reset;
  logic [63:0] sw;

  always #5 clk = ~clk;

  rom_download_ctrl #(.ROM_BYTES(ROM_BYTES), .DN_AW(16), .HOLD_CYCLES(HOLD)) dut (
    .CLK(clk), .RESET(rst),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .mod(mod), .sw(sw), .rom_valid(rom_valid), .rom_ovf(rom_ovf), .core_reset(core_reset)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0, n_err = 0, n_pulse = 0, n_push = 0;
  logic [63:0] sw_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every in-range ROM write expects one dn_wr one cycle later.
  always @(negedge clk) begin
    if (dn_wr === 1'b1) begin
      n_pulse++;
      n_checks++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL dn_wr_spurious: observed pulse at addr %0h, expected none", dn_addr);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("dn_addr", 64'(dn_addr), 64'(mon_e.a));
        chk("dn_data", 64'(dn_data), 64'(mon_e.d));
        chk("dn_latency", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    if (ioctl_download && ioctl_index == IDX_ROM && a < ROM_BYTES && !rst) begin
      sb.push_back('{a: 16'(a), d: d, c: cyc + 1});
      n_push++;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  // Called just after the edge that starts the hold.
  task automatic hold_check(input string tag, input logic exp_run);
    repeat (HOLD - 1) tick();
    chk({tag, "_hold_last"}, 64'(core_reset), 64'(1));
    tick();
    chk({tag, "_hold_end"}, 64'(core_reset), 64'(!exp_run));
  endtask

  initial begin
    rst = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = 8'd0;
    sw_exp = '1;

    // Power-up / reset state
    tick();
    chk("rst_core_reset", 64'(core_reset), 64'(1));
    chk("rst_dn_wr",      64'(dn_wr),      64'(0));
    chk("rst_dn_addr",    64'(dn_addr),    64'(0));
    chk("rst_dn_data",    64'(dn_data),    64'(0));
    chk("rst_mod",        64'(mod),        64'(0));
    chk("rst_sw",         sw,              sw_exp);
    chk("rst_rom_valid",  64'(rom_valid),  64'(0));
    chk("rst_rom_ovf",    64'(rom_ovf),    64'(0));
    tick(); tick();
    rst = 1'b0;
    repeat (HOLD + 1) tick();
    chk("pwr_state_idle", 64'(dut.state), 64'(ST_IDLE));
    chk("pwr_core_reset", 64'(core_reset), 64'(1));

    // Unknown index: ignored entirely
    start_dl(8'd3);
    chk("idx3_state", 64'(dut.state), 64'(ST_IDLE));
    wr_byte(0, 8'h77);
    end_dl();
    chk("idx3_mod", 64'(mod), 64'(0));
    chk("idx3_sw",  sw, sw_exp);

    // DIP and MOD config
    start_dl(IDX_DIP);
    chk("dip_state", 64'(dut.state), 64'(ST_LOAD_CFG));
    wr_byte(2, 8'h5A);
    sw_exp[23:16] = 8'h5A;
    chk("dip_addr2", sw, sw_exp);
    wr_byte(9, 8'h5A);
    chk("dip_addr9", sw, sw_exp);
    end_dl();
    start_dl(IDX_MOD);
    wr_byte(0, 8'd5);
    chk("mod_5", 64'(mod), 64'(5));
    wr_byte(1, 8'd11);
    chk("mod_11", 64'(mod), 64'(11));
    end_dl();
    repeat (HOLD + 1) tick();
    chk("cfg_state_idle", 64'(dut.state), 64'(ST_IDLE));
    chk("cfg_core_reset", 64'(core_reset), 64'(1));

    // Full ROM load
    start_dl(IDX_ROM);
    chk("full_core_reset_start", 64'(core_reset), 64'(1));
    for (int a = 0; a < ROM_BYTES; a++) wr_byte(a, 8'(a));
    chk("full_core_reset_load", 64'(core_reset), 64'(1));
    chk("full_rom_ovf", 64'(rom_ovf), 64'(0));
    end_dl();
    chk("full_rom_valid", 64'(rom_valid), 64'(1));
    hold_check("full", 1'b1);
    chk("full_dn_addr_held", 64'(dn_addr), 64'(16'h3FFF));
    chk("full_dn_data_held", 64'(dn_data), 64'(8'hFF));
    chk("full_sb_empty", 64'(sb.size()), 64'(0));

    // RESET while running
    rst = 1'b1;
    tick();
    chk("rrun_core_reset", 64'(core_reset), 64'(1));
    chk("rrun_dn_addr",    64'(dn_addr),    64'(0));
    chk("rrun_dn_data",    64'(dn_data),    64'(0));
    tick(); tick();
    rst = 1'b0;
    hold_check("rrun", 1'b1);
    chk("rrun_mod",       64'(mod), 64'(11));
    chk("rrun_sw",        sw, sw_exp);
    chk("rrun_rom_valid", 64'(rom_valid), 64'(1));

    // Download start during HOLD restarts the hold
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (500) tick();
    chk("dlh_core_reset", 64'(core_reset), 64'(1));
    start_dl(IDX_MOD);
    chk("dlh_state", 64'(dut.state), 64'(ST_LOAD_CFG));
    wr_byte(0, 8'd11);
    end_dl();
    chk("dlh_rom_valid", 64'(rom_valid), 64'(1));
    hold_check("dlh", 1'b1);

    // Overflow: one byte past the end
    start_dl(IDX_ROM);
    chk("ovf_valid_cleared", 64'(rom_valid), 64'(0));
    for (int a = 0; a <= ROM_BYTES; a++) wr_byte(a, 8'(a ^ 8'h3C));
    chk("ovf_rom_ovf", 64'(rom_ovf), 64'(1));
    end_dl();
    chk("ovf_rom_valid", 64'(rom_valid), 64'(0));
    hold_check("ovf", 1'b0);
    tick();
    chk("ovf_state_idle", 64'(dut.state), 64'(ST_IDLE));
    chk("ovf_core_reset", 64'(core_reset), 64'(1));

    // Short image
    start_dl(IDX_ROM);
    chk("short_ovf_cleared", 64'(rom_ovf), 64'(0));
    for (int a = 0; a < 100; a++) wr_byte(a, 8'(a + 7));
    end_dl();
    chk("short_rom_valid", 64'(rom_valid), 64'(0));
    hold_check("short", 1'b0);

    // RESET in the middle of a ROM download
    start_dl(IDX_ROM);
    for (int a = 0; a < ROM_BYTES / 2; a++) wr_byte(a, 8'(a));
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("mid_state_hold", 64'(dut.state), 64'(ST_HOLD));
    for (int a = ROM_BYTES / 2; a < ROM_BYTES; a++) wr_byte(a, 8'(a));
    end_dl();
    repeat (4) tick();
    chk("mid_rom_valid",  64'(rom_valid), 64'(0));
    chk("mid_core_reset", 64'(core_reset), 64'(1));
    chk("mid_state_idle", 64'(dut.state), 64'(ST_IDLE));

    chk("end_sb_empty",    64'(sb.size()), 64'(0));
    chk("end_pulse_count", 64'(n_pulse), 64'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
